dm_arbiter: RTL and testbench

DM_ARBITER -- requirements
Module: dm_arbiter

---
 rtl/dm_arbiter_pkg.sv | 31 +++
 rtl/dm_burst_agu.sv | 76 +++++++
 rtl/dm_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_dm_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dm_arbiter_pkg
//  Description : Shared types and constants for the data-memory arbiter.
//                Holds the FSM state encoding, the port-select encoding,
//                the default parameter values and the word-index width.
//  Revision    : 1.0 - initial release
// ============================================================================
package dm_arbiter_pkg;

    // Default burst-length field width (burst length = len + 1, 1..16).
    localparam int DEF_BURST_W = 4;
    // Default data-memory depth in words.
    localparam int DEF_WORDS   = 1024;
    // Word-index width for the default depth (address[11:2]).
    localparam int DM_IDX_W    = 10;

    // Arbiter FSM state encoding.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    // Round-robin pointer / port-select encoding.
    typedef enum logic [0:0] {
        SEL_M0 = 1'b0,
        SEL_M1 = 1'b1
    } port_sel_e;

endpackage : dm_arbiter_pkg
`default_nettype wire

// File: rtl/dm_burst_agu.sv
`default_nettype none
// ============================================================================
//  Module      : dm_burst_agu
//  Description : Burst address generator for the M1 port. Latches the
//                word-aligned start address, write enable and length at burst
//                start, tracks the beat counter, wraps the word index modulo
//                WORDS and flags the final beat.
//  Ports       : clk_i, rst_ni        - clock, async active-low reset
//                start_i              - latch burst parameters (beat 0 grant)
//                start_addr_i[31:2]   - word address of the burst start
//                start_we_i, start_len_i - burst write enable / length-1
//                advance_i            - a burst beat (>=1) is performed
//                addr_o               - byte address of the current beat
//                we_o                 - latched write enable
//                last_o               - current beat is the final one
//  Revision    : 1.0 - initial release
// ============================================================================
module dm_burst_agu
    import dm_arbiter_pkg::*;
#(
    parameter int BURST_W = DEF_BURST_W,
    parameter int WORDS   = DEF_WORDS
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic [31:2]         start_addr_i,
    input  logic                start_we_i,
    input  logic [BURST_W-1:0]  start_len_i,
    input  logic                advance_i,
    output logic [31:0]         addr_o,
    output logic                we_o,
    output logic                last_o
);

    localparam int              IDX_W   = $clog2(WORDS);
    localparam logic [IDX_W:0]  WORDS_V = (IDX_W+1)'(WORDS);

    logic [31:2]        start_q;
    logic               we_q;
    logic [BURST_W-1:0] len_q;
    logic [BURST_W-1:0] cnt_q;

    logic [IDX_W:0]     sum;
    logic [IDX_W-1:0]   idx;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            start_q <= '0;
            we_q    <= 1'b0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else if (start_i) begin
            start_q <= start_addr_i;
            we_q    <= start_we_i;
            len_q   <= start_len_i;
            // Beat 0 is performed in the start cycle; a single-beat burst
            // never enters BURST, so its counter stays at zero.
            cnt_q   <= (start_len_i == '0) ? '0 : BURST_W'(1);
        end else if (advance_i) begin
            cnt_q   <= last_o ? '0 : cnt_q + BURST_W'(1);
        end
    end

    // One extra bit of headroom so a single conditional subtract wraps the
    // index even when WORDS is not a power of two.
    assign sum    = {1'b0, start_q[IDX_W+1:2]} + (IDX_W+1)'(cnt_q);
    assign idx    = (sum >= WORDS_V) ? IDX_W'(sum - WORDS_V) : IDX_W'(sum);

    // Upper address bits stay at the start value across the wrap.
    assign addr_o = {start_q[31:IDX_W+2], idx, 2'b00};
    assign we_o   = we_q;
    assign last_o = (cnt_q == len_q);

endmodule : dm_burst_agu
`default_nettype wire

// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dm_arbiter
//  Description : Two-master arbiter for a single-port data memory. M0 is the
//                pipeline MEM stage (single-word, granted combinationally),
//                M1 is a burst port (loader/DMA). Contention in IDLE is
//                resolved by a round-robin pointer; once a burst starts M1
//                owns the memory until its final beat.
//  Ports       : clk_i, rst_ni                 - clock, async active-low reset
//                m0_*_i / m0_gnt_o, m0_rd_o    - single-word master
//                m1_*_i / m1_gnt_o, m1_rd_o,
//                m1_done_o                     - burst master
//                mem_we_o, mem_addr_o, mem_wd_o,
//                mem_pc_o, mem_rd_i            - data-memory port
//                err_o                         - misaligned M0 access pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int BURST_W = DEF_BURST_W,
    parameter int WORDS   = DEF_WORDS
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    // M0: pipeline MEM stage
    input  logic                m0_req_i,
    input  logic                m0_we_i,
    input  logic [31:0]         m0_addr_i,
    input  logic [31:0]         m0_wd_i,
    input  logic [31:0]         m0_pc_i,
    output logic                m0_gnt_o,
    output logic [31:0]         m0_rd_o,
    // M1: burst port
    input  logic                m1_req_i,
    input  logic                m1_we_i,
    input  logic [31:0]         m1_addr_i,
    input  logic [BURST_W-1:0]  m1_len_i,
    input  logic [31:0]         m1_wd_i,
    output logic                m1_gnt_o,
    output logic [31:0]         m1_rd_o,
    output logic                m1_done_o,
    // Data memory
    output logic                mem_we_o,
    output logic [31:0]         mem_addr_o,
    output logic [31:0]         mem_wd_o,
    output logic [31:0]         mem_pc_o,
    input  logic [31:0]         mem_rd_i,
    // Status
    output logic                err_o
);

    state_e     state_q, state_d;
    port_sel_e  ptr_q;

    logic        m0_win;
    logic        m1_win;
    logic        m0_misal;
    logic        len_zero;
    logic        agu_adv;
    logic [31:0] agu_addr;
    logic        agu_we;
    logic        agu_last;

    // ------------------------------------------------------------------
    // Arbitration (only meaningful in IDLE)
    // ------------------------------------------------------------------
    assign m0_win   = (state_q == ST_IDLE) && m0_req_i &&
                      (!m1_req_i || (ptr_q == SEL_M0));
    assign m1_win   = (state_q == ST_IDLE) && m1_req_i &&
                      (!m0_req_i || (ptr_q == SEL_M1));
    assign m0_misal = |m0_addr_i[1:0];
    assign len_zero = (m1_len_i == '0);
    assign agu_adv  = (state_q == ST_BURST) && m1_req_i;

    dm_burst_agu #(
        .BURST_W (BURST_W),
        .WORDS   (WORDS)
    ) u_agu (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (m1_win),
        .start_addr_i (m1_addr_i[31:2]),
        .start_we_i   (m1_we_i),
        .start_len_i  (m1_len_i),
        .advance_i    (agu_adv),
        .addr_o       (agu_addr),
        .we_o         (agu_we),
        .last_o       (agu_last)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (m1_win && !len_zero) begin
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                if (m1_req_i && agu_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic. Everything is qualified with rst_ni so that no
    // grant or write escapes while reset is held, even though the grants
    // are combinational on the request inputs.
    // ------------------------------------------------------------------
    always_comb begin
        m0_gnt_o   = 1'b0;
        m1_gnt_o   = 1'b0;
        m1_done_o  = 1'b0;
        err_o      = 1'b0;
        mem_we_o   = 1'b0;
        mem_addr_o = m0_addr_i;
        mem_wd_o   = m0_wd_i;
        mem_pc_o   = 32'h0;
        if (rst_ni) begin
            case (state_q)
                ST_IDLE: begin
                    if (m0_win) begin
                        m0_gnt_o = 1'b1;
                        mem_pc_o = m0_pc_i;
                        err_o    = m0_misal;
                        mem_we_o = m0_we_i && !m0_misal;
                    end else if (m1_win) begin
                        // Beat 0 is addressed straight from the inputs; the
                        // generator only takes over from beat 1.
                        m1_gnt_o   = 1'b1;
                        mem_addr_o = m1_addr_i & ~32'h3;
                        mem_wd_o   = m1_wd_i;
                        mem_we_o   = m1_we_i;
                        m1_done_o  = len_zero;
                    end
                end
                ST_BURST: begin
                    if (m1_req_i) begin
                        m1_gnt_o   = 1'b1;
                        mem_addr_o = agu_addr;
                        mem_wd_o   = m1_wd_i;
                        mem_we_o   = agu_we;
                        m1_done_o  = agu_last;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Round-robin pointer: hand priority to M1 after any M0 access and
    // back to M0 once a burst has completed.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= SEL_M0;
        end else if (m0_gnt_o) begin
            ptr_q <= SEL_M1;
        end else if (m1_done_o) begin
            ptr_q <= SEL_M0;
        end
    end

    assign m0_rd_o = mem_rd_i;
    assign m1_rd_o = mem_rd_i;

endmodule : dm_arbiter
`default_nettype wire

// File: tb/tb_dm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dm_arbiter
//  Description : Directed self-checking bench for dm_arbiter with a simple
//                behavioural single-port data memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_arbiter;

    localparam int BURST_W = 4;
    localparam int WORDS   = 1024;

    logic               clk;
    logic               rst_n;
    logic               m0_req, m0_we;
    logic [31:0]        m0_addr, m0_wd, m0_pc, m0_rd;
    logic               m0_gnt;
    logic               m1_req, m1_we;
    logic [31:0]        m1_addr, m1_wd, m1_rd;
    logic [BURST_W-1:0] m1_len;
    logic               m1_gnt, m1_done;
    logic               mem_we;
    logic [31:0]        mem_addr, mem_wd, mem_pc, mem_rd;
    logic               err;

    int checks = 0;
    int errors = 0;

    logic [31:0] tb_mem [0:WORDS-1] = '{default: 32'h0};

    dm_arbiter #(
        .BURST_W (BURST_W),
        .WORDS   (WORDS)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .m0_req_i   (m0_req),
        .m0_we_i    (m0_we),
        .m0_addr_i  (m0_addr),
        .m0_wd_i    (m0_wd),
        .m0_pc_i    (m0_pc),
        .m0_gnt_o   (m0_gnt),
        .m0_rd_o    (m0_rd),
        .m1_req_i   (m1_req),
        .m1_we_i    (m1_we),
        .m1_addr_i  (m1_addr),
        .m1_len_i   (m1_len),
        .m1_wd_i    (m1_wd),
        .m1_gnt_o   (m1_gnt),
        .m1_rd_o    (m1_rd),
        .m1_done_o  (m1_done),
        .mem_we_o   (mem_we),
        .mem_addr_o (mem_addr),
        .mem_wd_o   (mem_wd),
        .mem_pc_o   (mem_pc),
        .mem_rd_i   (mem_rd),
        .err_o      (err)
    );

    // Behavioural data memory: posedge write, combinational read.
    assign mem_rd = tb_mem[mem_addr[11:2]];
    always @(posedge clk) begin
        if (mem_we) tb_mem[mem_addr[11:2]] <= mem_wd;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [31:0] wrap_a [4] = '{32'h12345FF8, 32'h12345FFC, 32'h12345000, 32'h12345004};
    logic [31:0] rb_a   [4] = '{32'h100, 32'h104, 32'h108, 32'h10C};
    logic [31:0] rb_d   [4] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};

    initial begin
        // ---------------- reset state, requests active ----------------
        rst_n = 1'b0;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h13; m0_wd = 32'h0; m0_pc = 32'h0;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h0; m1_len = 4'd0; m1_wd = 32'h0;
        @(negedge clk); #1;
        chk("rst_m0_gnt", 32'(m0_gnt), 32'h0);
        chk("rst_m1_gnt", 32'(m1_gnt), 32'h0);
        chk("rst_m1_done", 32'(m1_done), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        @(negedge clk);
        rst_n = 1'b1; m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0;

        // ---------------- M0 write then read ----------------
        @(negedge clk);
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h10; m0_wd = 32'hDEADBEEF; m0_pc = 32'h100;
        #1;
        chk("m0w_gnt", 32'(m0_gnt), 32'h1);
        chk("m0w_mem_we", 32'(mem_we), 32'h1);
        chk("m0w_mem_addr", mem_addr, 32'h10);
        chk("m0w_mem_pc", mem_pc, 32'h100);
        @(negedge clk);
        m0_we = 1'b0; #1;
        chk("m0r_gnt", 32'(m0_gnt), 32'h1);
        chk("m0r_rd", m0_rd, 32'hDEADBEEF);

        // ---------------- misaligned M0 write ----------------
        @(negedge clk);
        m0_we = 1'b1; m0_addr = 32'h13; m0_wd = 32'h12345678; #1;
        chk("mis_gnt", 32'(m0_gnt), 32'h1);
        chk("mis_err", 32'(err), 32'h1);
        chk("mis_mem_we", 32'(mem_we), 32'h0);
        @(negedge clk);
        m0_we = 1'b0; m0_addr = 32'h10; #1;
        chk("mis_err_clr", 32'(err), 32'h0);
        chk("mis_mem_kept", m0_rd, 32'hDEADBEEF);
        @(negedge clk);
        m0_req = 1'b0; #1;
        chk("idle_m0_gnt", 32'(m0_gnt), 32'h0);

        // ---------------- M1 burst write 0x0, len 3, data 1..4 ----------------
        m1_we = 1'b1; m1_addr = 32'h0; m1_len = 4'd3;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            m1_req = 1'b1; m1_wd = 32'(k + 1);
            if (k == 1) begin
                // Burst parameters must have been captured at beat 0.
                m1_addr = 32'h800; m1_len = 4'd0; m1_we = 1'b0;
            end
            #1;
            chk($sformatf("b44_gnt%0d", k), 32'(m1_gnt), 32'h1);
            chk($sformatf("b44_addr%0d", k), mem_addr, 32'(4 * k));
            chk($sformatf("b44_we%0d", k), 32'(mem_we), 32'h1);
            chk($sformatf("b44_pc%0d", k), mem_pc, 32'h0);
            chk($sformatf("b44_done%0d", k), 32'(m1_done), (k == 3) ? 32'h1 : 32'h0);
        end
        for (int w = 0; w < 4; w++) begin
            @(negedge clk);
            m1_req = 1'b0; m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'(4 * w); #1;
            chk($sformatf("b44_word%0d", w), m0_rd, 32'(w + 1));
        end
        @(negedge clk);
        m0_req = 1'b0;

        // ---------------- contention from reset ----------------
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h4;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h40; m1_len = 4'd1;
        #1;
        chk("rr1_m0_gnt", 32'(m0_gnt), 32'h1);
        chk("rr1_m1_gnt", 32'(m1_gnt), 32'h0);
        chk("rr1_m0_rd", m0_rd, 32'h2);
        @(negedge clk); #1;
        chk("rr2_m1_gnt", 32'(m1_gnt), 32'h1);
        chk("rr2_m0_gnt", 32'(m0_gnt), 32'h0);
        chk("rr2_addr", mem_addr, 32'h40);
        chk("rr2_done", 32'(m1_done), 32'h0);
        @(negedge clk); #1;
        chk("rr3_m1_gnt", 32'(m1_gnt), 32'h1);
        chk("rr3_m0_gnt", 32'(m0_gnt), 32'h0);
        chk("rr3_addr", mem_addr, 32'h44);
        chk("rr3_done", 32'(m1_done), 32'h1);
        @(negedge clk); #1;
        chk("rr4_m0_gnt", 32'(m0_gnt), 32'h1);
        chk("rr4_m1_gnt", 32'(m1_gnt), 32'h0);
        @(negedge clk);
        m0_req = 1'b0; m1_req = 1'b0;

        // ---------------- wrap: start 0x...FFA (forced to FFA & ~3) ----------------
        m1_we = 1'b0; m1_addr = 32'h12345FFA; m1_len = 4'd3;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            m1_req = 1'b1; #1;
            chk($sformatf("wrap_gnt%0d", k), 32'(m1_gnt), 32'h1);
            chk($sformatf("wrap_addr%0d", k), mem_addr, wrap_a[k]);
            chk($sformatf("wrap_done%0d", k), 32'(m1_done), (k == 3) ? 32'h1 : 32'h0);
        end

        // ---------------- stalled burst with M0 pressure ----------------
        @(negedge clk);
        m0_req = 1'b0;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h100; m1_len = 4'd3; m1_wd = 32'hA0; #1;
        chk("st_b0_gnt", 32'(m1_gnt), 32'h1);
        chk("st_b0_addr", mem_addr, 32'h100);
        @(negedge clk);
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h100; m0_wd = 32'h55; m1_wd = 32'hA1; #1;
        chk("st_b1_gnt", 32'(m1_gnt), 32'h1);
        chk("st_b1_m0_gnt", 32'(m0_gnt), 32'h0);
        chk("st_b1_addr", mem_addr, 32'h104);
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            m1_req = 1'b0; m1_wd = 32'hBAD; #1;
            chk($sformatf("st_stall%0d_m1_gnt", s), 32'(m1_gnt), 32'h0);
            chk($sformatf("st_stall%0d_m0_gnt", s), 32'(m0_gnt), 32'h0);
            chk($sformatf("st_stall%0d_we", s), 32'(mem_we), 32'h0);
        end
        @(negedge clk);
        m1_req = 1'b1; m1_wd = 32'hA2; #1;
        chk("st_b2_gnt", 32'(m1_gnt), 32'h1);
        chk("st_b2_addr", mem_addr, 32'h108);
        chk("st_b2_done", 32'(m1_done), 32'h0);
        chk("st_b2_m0_gnt", 32'(m0_gnt), 32'h0);
        @(negedge clk);
        m1_wd = 32'hA3; #1;
        chk("st_b3_addr", mem_addr, 32'h10C);
        chk("st_b3_done", 32'(m1_done), 32'h1);
        chk("st_b3_m0_gnt", 32'(m0_gnt), 32'h0);
        for (int w = 0; w < 4; w++) begin
            @(negedge clk);
            m1_req = 1'b0; m0_we = 1'b0; m0_addr = rb_a[w]; #1;
            chk($sformatf("st_rd%0d_gnt", w), 32'(m0_gnt), 32'h1);
            chk($sformatf("st_rd%0d", w), m0_rd, rb_d[w]);
        end

        // ---------------- reset at beat 2 aborts the burst ----------------
        @(negedge clk);
        m0_req = 1'b0;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h300; m1_len = 4'd3; m1_wd = 32'hB0; #1;
        chk("ab_b0_gnt", 32'(m1_gnt), 32'h1);
        @(negedge clk);
        m1_wd = 32'hB1; #1;
        chk("ab_b1_addr", mem_addr, 32'h304);
        @(negedge clk);
        rst_n = 1'b0; m1_wd = 32'hB2; #1;
        chk("ab_rst_gnt", 32'(m1_gnt), 32'h0);
        chk("ab_rst_done", 32'(m1_done), 32'h0);
        chk("ab_rst_we", 32'(mem_we), 32'h0);
        @(negedge clk); #1;
        chk("ab_rst2_done", 32'(m1_done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1; m1_req = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h308; #1;
        chk("ab_idle_m0_gnt", 32'(m0_gnt), 32'h1);
        chk("ab_idle_done", 32'(m1_done), 32'h0);
        chk("ab_beat2_unwritten", m0_rd, 32'h0);
        @(negedge clk);
        m0_addr = 32'h304; #1;
        chk("ab_beat1_written", m0_rd, 32'hB1);
        @(negedge clk);
        m0_req = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_dm_arbiter
`default_nettype wire
